ext_bus_ctrl: RTL and testbench

//  Half-duplex controller for an 8-bit bidirectional external data bus built from per-bit tristate IO buffers.

---
 rtl/ext_bus_ctrl.sv | 143 ++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_ctrl.sv
// Half-duplex strobe controller for a tristated external data bus; all outputs registered.
// One transfer busies the port for 1+STB_CYC+1+TA_CYC cycles; req is only taken while ready is high.
module ext_bus_ctrl #(
   parameter int DW      = 8,
   parameter int STB_CYC = 4,
   parameter int TA_CYC  = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req,
   input  logic          we,
   input  logic [DW-1:0] wdata,
   output logic          ready,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic [DW-1:0] pad_o,
   output logic [DW-1:0] pad_t,
   input  logic [DW-1:0] pad_i,
   output logic          strb_n,
   output logic          rw
);

   localparam int MAXC = (STB_CYC > TA_CYC) ? STB_CYC : TA_CYC;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] STB_LD = CW'(STB_CYC - 1);
   localparam logic [CW-1:0] TA_LD  = CW'(TA_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic          ready_q, ready_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] pad_o_q, pad_o_d;
   logic [DW-1:0] pad_t_q, pad_t_d;
   logic          strb_n_q, strb_n_d;
   logic          rw_q, rw_d;

   // Outputs are registered, so each branch sets the values for the state being entered.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      ready_d  = ready_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      pad_o_d  = pad_o_q;
      pad_t_d  = pad_t_q;
      strb_n_d = strb_n_q;
      rw_d     = rw_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = SETUP;
               we_d    = we;
               ready_d = 1'b0;
               rw_d    = ~we;
               if (we) begin
                  pad_o_d = wdata;
                  pad_t_d = '0;
               end
            end
         end
         SETUP: begin
            state_d  = STROBE;
            cnt_d    = STB_LD;
            strb_n_d = 1'b0;
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d  = HOLD;
               strb_n_d = 1'b1;
               if (!we_q) begin
                  rdata_d  = pad_i;
                  rvalid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            state_d = TURN;
            cnt_d   = TA_LD;
            pad_t_d = '1;
            pad_o_d = '0;
            rw_d    = 1'b1;
         end
         TURN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            pad_t_d  = '1;
            pad_o_d  = '0;
            strb_n_d = 1'b1;
            rw_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         ready_q  <= 1'b1;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         pad_o_q  <= '0;
         pad_t_q  <= '1;
         strb_n_q <= 1'b1;
         rw_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         pad_o_q  <= pad_o_d;
         pad_t_q  <= pad_t_d;
         strb_n_q <= strb_n_d;
         rw_q     <= rw_d;
      end
   end

   assign ready  = ready_q;
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign pad_o  = pad_o_q;
   assign pad_t  = pad_t_q;
   assign strb_n = strb_n_q;
   assign rw     = rw_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench: stimulus pushes expected per-cycle bus snapshots, monitors pop them on falling edges.
module tb_ext_bus_ctrl;

   typedef struct packed {
      logic       ready;
      logic       strb_n;
      logic       rw;
      logic [7:0] pad_t;
      logic [7:0] pad_o;
      logic       rvalid;
      logic [7:0] rdata;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req = 1'b0, we = 1'b0;
   logic [7:0] wdata = '0, pad_i = '0;
   logic       ready, rvalid, strb_n, rw;
   logic [7:0] rdata, pad_o, pad_t;

   logic       req2 = 1'b0, we2 = 1'b0;
   logic [7:0] wdata2 = '0, pad_i2 = '0;
   logic       ready2, rvalid2, strb_n2, rw2;
   logic [7:0] rdata2, pad_o2, pad_t2;

   obs_t       exp_q[$];
   obs_t       exp2_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] mdl_rdata = '0;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   ext_bus_ctrl #(.DW(8), .STB_CYC(4), .TA_CYC(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .wdata(wdata),
      .ready(ready), .rdata(rdata), .rvalid(rvalid), .pad_o(pad_o), .pad_t(pad_t),
      .pad_i(pad_i), .strb_n(strb_n), .rw(rw)
   );

   ext_bus_ctrl #(.DW(8), .STB_CYC(1), .TA_CYC(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .req(req2), .we(we2), .wdata(wdata2),
      .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .pad_o(pad_o2), .pad_t(pad_t2),
      .pad_i(pad_i2), .strb_n(strb_n2), .rw(rw2)
   );

   // Expected snapshot k cycles after acceptance (k=0 is the idle cycle holding the request).
   function automatic obs_t xrec(int k, bit w, logic [7:0] d, logic [7:0] pi,
                                 int s, int t, logic [7:0] old);
      obs_t r;
      bit   drive;
      drive    = w && k >= 1 && k <= 2 + s;
      r.ready  = (k == 0) || (k > 2 + s + t);
      r.strb_n = !(k >= 2 && k <= 1 + s);
      r.rw     = !drive;
      r.pad_t  = drive ? 8'h00 : 8'hFF;
      r.pad_o  = drive ? d : 8'h00;
      r.rvalid = !w && k == 2 + s;
      r.rdata  = (!w && k >= 2 + s) ? pi : old;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Caller enters at posedge+1; returns at posedge+1 of the first idle cycle afterwards.
   task automatic xfer(input bit w, input logic [7:0] d, input logic [7:0] pi,
                       input bit keep, input bit pulse);
      req = 1'b1; we = w; wdata = d; pad_i = pi;
      for (int k = 0; k <= 8; k++) exp_q.push_back(xrec(k, w, d, pi, 4, 2, mdl_rdata));
      if (!w) begin
         rd_q.push_back(pi);
         mdl_rdata = pi;
      end
      @(posedge clk); #1;
      req = keep;
      for (int i = 2; i <= 9; i++) begin
         @(posedge clk); #1;
         if (pulse) req = (i == 2);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(xrec(0, 1'b0, 8'h00, 8'h00, 4, 2, mdl_rdata));
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin : mon1
      obs_t e, a;
      a = '{ready, strb_n, rw, pad_t, pad_o, rvalid, rdata};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (a === e) n_pass++;
         else $display("FAIL trace @%0t: got rdy=%b stb_n=%b rw=%b t=%h o=%h rv=%b rd=%h expected rdy=%b stb_n=%b rw=%b t=%h o=%h rv=%b rd=%h",
                       $time, a.ready, a.strb_n, a.rw, a.pad_t, a.pad_o, a.rvalid, a.rdata,
                       e.ready, e.strb_n, e.rw, e.pad_t, e.pad_o, e.rvalid, e.rdata);
      end
      if (rvalid === 1'b1) begin
         if (rd_q.size() == 0) begin
            n_chk++;
            $display("FAIL rvalid_unexpected @%0t: got rvalid=1 expected 0", $time);
         end else begin
            chk("rdata_on_rvalid", {24'h0, rdata}, {24'h0, rd_q.pop_front()});
         end
      end
   end

   always @(negedge clk) begin : mon2
      obs_t e, a;
      a = '{ready2, strb_n2, rw2, pad_t2, pad_o2, rvalid2, rdata2};
      if (exp2_q.size() > 0) begin
         e = exp2_q.pop_front();
         n_chk++;
         if (a === e) n_pass++;
         else $display("FAIL trace_min @%0t: got rdy=%b stb_n=%b rw=%b t=%h o=%h rv=%b rd=%h expected rdy=%b stb_n=%b rw=%b t=%h o=%h rv=%b rd=%h",
                       $time, a.ready, a.strb_n, a.rw, a.pad_t, a.pad_o, a.rvalid, a.rdata,
                       e.ready, e.strb_n, e.rw, e.pad_t, e.pad_o, e.rvalid, e.rdata);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // Reset values observed while reset is still asserted.
      exp_q.push_back(xrec(0, 1'b0, 8'h00, 8'h00, 4, 2, 8'h00));
      exp_q.push_back(xrec(0, 1'b0, 8'h00, 8'h00, 4, 2, 8'h00));
      exp2_q.push_back(xrec(0, 1'b0, 8'h00, 8'h00, 1, 1, 8'h00));
      #22 reset_n = 1'b1;
      @(posedge clk); #1;

      xfer(1'b1, 8'hA5, 8'h00, 1'b0, 1'b0);
      xfer(1'b0, 8'h00, 8'h3C, 1'b0, 1'b0);
      // Read then write with req held across the busy period.
      xfer(1'b0, 8'h00, 8'h96, 1'b1, 1'b0);
      xfer(1'b1, 8'h5A, 8'h00, 1'b0, 1'b0);
      // Extra req pulse during the write strobe must not start a second transfer.
      xfer(1'b1, 8'hC3, 8'h00, 1'b0, 1'b1);
      idle(3);

      // Asynchronous reset in the middle of a write strobe.
      req = 1'b1; we = 1'b1; wdata = 8'h77;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_strobe", {31'h0, strb_n}, 32'h0);
      chk("pre_reset_pad_t", {24'h0, pad_t}, 32'h0);
      reset_n = 1'b0;
      #1;
      chk("arst_ready", {31'h0, ready}, 32'h1);
      chk("arst_pad_t", {24'h0, pad_t}, 32'hFF);
      chk("arst_strb_n", {31'h0, strb_n}, 32'h1);
      chk("arst_rdata", {24'h0, rdata}, 32'h0);
      mdl_rdata = 8'h00;
      #10 reset_n = 1'b1;
      @(posedge clk); #1;
      idle(2);

      // Minimum-timing instance: one strobe cycle, one turnaround cycle.
      req2 = 1'b1; we2 = 1'b0; pad_i2 = 8'h81;
      for (int k = 0; k <= 5; k++) exp2_q.push_back(xrec(k, 1'b0, 8'h00, 8'h81, 1, 1, 8'h00));
      @(posedge clk); #1;
      req2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end

      for (int i = 0; i < 20 && (exp_q.size() > 0 || exp2_q.size() > 0); i++) @(posedge clk);
      chk("queues_drained", exp_q.size() + exp2_q.size(), 32'h0);
      chk("reads_all_seen", rd_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
